snake_dir_decoder: RTL and testbench

- Sits downstream of the PS/2 keyboard receiver; consumes completed scan-code bytes in the clk100MHz domain.
- Tracks E0 (extended) and F0 (break) prefixes, maps arrow keys and WASD make codes to snake direction commands, and suppresses typematic repeats.
- Queues commands in a small first-word-fall-through FIFO for the snake game logic, and exposes the last make code for the seven-segment display.

---
 rtl/snake_dir_decoder_if.sv | 35 +++
 rtl/snake_dir_decoder.sv | 230 +++++++++++++++++++++++
 tb/tb_snake_dir_decoder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_dir_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_dir_decoder_if
//  Description : Scan-code input, direction-command output and status bundle
//                between the PS/2 receiver / game logic and the
//                snake_dir_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface snake_dir_decoder_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]         codeIn;
  logic               codeValid;
  logic               dirReady;
  logic [1:0]         dirOut;
  logic               dirValid;
  logic [c_CNT_W-1:0] fifoCount;
  logic               overflow;
  logic [15:0]        dispCode;

  // Producer side: supplies scan codes and the consumer's ready.
  modport master (
    output codeIn, codeValid, dirReady,
    input  dirOut, dirValid, fifoCount, overflow, dispCode
  );

  // Decoder side.
  modport slave (
    input  codeIn, codeValid, dirReady,
    output dirOut, dirValid, fifoCount, overflow, dispCode
  );
endinterface
`default_nettype wire

// File: rtl/snake_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : snake_dir_decoder
//  Description : Decodes PS/2 scan-code bytes (E0/F0 prefixes) into snake
//                direction commands, suppresses typematic repeats and queues
//                the commands in a first-word-fall-through FIFO.
//                Optional macro SNAKE_REVERSE_BLOCK_EN: refuse a command that
//                is the exact reverse of the last queued direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_decoder #(
  parameter int FIFO_DEPTH     = 4,        // power of two, 2..16
  parameter int TIMEOUT_CYCLES = 2000000   // idle cycles before a prefix is abandoned
) (
  input wire                 clk100MHz,
  input wire                 resetN,
  snake_dir_decoder_if.slave bus
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [7:0] c_CODE_EXT = 8'hE0;
  localparam logic [7:0] c_CODE_BRK = 8'hF0;

  localparam logic [1:0] c_DIR_UP    = 2'b00;
  localparam logic [1:0] c_DIR_RIGHT = 2'b01;
  localparam logic [1:0] c_DIR_DOWN  = 2'b10;
  localparam logic [1:0] c_DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  // Prefix tracking
  state_t              r_state;
  logic [c_TO_W-1:0]   r_timeout;

  // Held key and display
  logic                r_held_valid;
  logic [8:0]          r_held_key;
  logic [15:0]         r_disp;

  // Command FIFO
  logic [1:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_overflow;

  // Decode results for the byte presented this cycle
  logic                w_make;
  logic                w_brk;
  logic                w_ext;
  logic [8:0]          w_key;
  logic                w_mapped;
  logic [1:0]          w_dir;
  logic                w_repeat;
  logic                w_new_make;
  logic                w_block;
  logic                w_push_req;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  // Classify the incoming byte as a completed make, a completed break, or a prefix.
  always_comb begin
    w_make = 1'b0;
    w_brk  = 1'b0;
    w_ext  = 1'b0;
    if (bus.codeValid) begin
      case (r_state)
        S_IDLE: begin
          if (bus.codeIn != c_CODE_EXT && bus.codeIn != c_CODE_BRK) begin
            w_make = 1'b1;
          end
        end
        S_EXT: begin
          if (bus.codeIn != c_CODE_EXT && bus.codeIn != c_CODE_BRK) begin
            w_make = 1'b1;
            w_ext  = 1'b1;
          end
        end
        S_BRK: begin
          w_brk = 1'b1;
        end
        default: begin
          w_brk = 1'b1;
          w_ext = 1'b1;
        end
      endcase
    end
  end

  assign w_key = {w_ext, bus.codeIn};

  // Arrow keys (extended) and WASD map onto the four snake directions.
  always_comb begin
    w_mapped = 1'b1;
    w_dir    = c_DIR_UP;
    case (w_key)
      {1'b1, 8'h75}, {1'b0, 8'h1D}: w_dir = c_DIR_UP;
      {1'b1, 8'h74}, {1'b0, 8'h23}: w_dir = c_DIR_RIGHT;
      {1'b1, 8'h72}, {1'b0, 8'h1B}: w_dir = c_DIR_DOWN;
      {1'b1, 8'h6B}, {1'b0, 8'h1C}: w_dir = c_DIR_LEFT;
      default:                      w_mapped = 1'b0;
    endcase
  end

  assign w_repeat   = r_held_valid && (r_held_key == w_key);
  assign w_new_make = w_make && w_mapped && !w_repeat;

`ifdef SNAKE_REVERSE_BLOCK_EN
  logic       r_last_valid;
  logic [1:0] r_last_dir;

  // Remember the last direction that entered the queue so its reverse can be refused.
  always_ff @(posedge clk100MHz or negedge resetN) begin
    if (!resetN) begin
      r_last_valid <= 1'b0;
      r_last_dir   <= c_DIR_UP;
    end else if (w_push) begin
      r_last_valid <= 1'b1;
      r_last_dir   <= w_dir;
    end
  end

  assign w_block = r_last_valid && (w_dir == (r_last_dir ^ 2'b10));
`else
  assign w_block = 1'b0;
`endif

  assign w_push_req = w_new_make && !w_block;
  assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty && bus.dirReady;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Prefix state machine with idle timeout that abandons a dangling E0/F0.
  always_ff @(posedge clk100MHz or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_timeout <= '0;
    end else if (bus.codeValid) begin
      r_timeout <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.codeIn == c_CODE_EXT) begin
            r_state <= S_EXT;
          end else if (bus.codeIn == c_CODE_BRK) begin
            r_state <= S_BRK;
          end
        end
        S_EXT: begin
          if (bus.codeIn == c_CODE_BRK) begin
            r_state <= S_EXT_BRK;
          end else if (bus.codeIn != c_CODE_EXT) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_timeout == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
        r_state   <= S_IDLE;
        r_timeout <= '0;
      end else begin
        r_timeout <= r_timeout + c_TO_W'(1);
      end
    end
  end

  // Track the held key for repeat suppression and latch the last accepted make for display.
  always_ff @(posedge clk100MHz or negedge resetN) begin
    if (!resetN) begin
      r_held_valid <= 1'b0;
      r_held_key   <= '0;
      r_disp       <= '0;
    end else if (w_new_make) begin
      r_held_valid <= 1'b1;
      r_held_key   <= w_key;
      r_disp       <= {(w_ext ? c_CODE_EXT : 8'h00), bus.codeIn};
    end else if (w_brk && w_repeat) begin
      r_held_valid <= 1'b0;
    end
  end

  // Command FIFO storage, pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk100MHz or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= c_DIR_UP;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_drop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dir;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  assign bus.dirOut    = r_mem[r_rd_ptr];
  assign bus.dirValid  = !w_empty;
  assign bus.fifoCount = r_count;
  assign bus.overflow  = r_overflow;
  assign bus.dispCode  = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_dir_decoder
//  Description : Self-checking bench for snake_dir_decoder: directed vector
//                table, hand-written prefix-timeout / reset / reverse
//                sequences, and random scan-code traffic against a
//                queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_dir_decoder;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  snake_dir_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  snake_dir_decoder #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk100MHz (clk),
    .resetN    (rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int          m_q[$];     // queued directions, head at index 0
  bit          m_ext;      // E0 seen, sequence pending
  bit          m_brk;      // F0 seen, sequence pending
  int          m_idle;     // idle cycles since last byte while pending
  int          m_held;     // {ext,code} of held key, -1 when none
  logic [15:0] m_disp;
  bit          m_ovf;
  int          m_last;     // last queued direction, -1 before the first
  int          rev_expect;

  function automatic int key_dir(int key);
    case (key)
      'h175, 'h01D: return 0;
      'h174, 'h023: return 1;
      'h172, 'h01B: return 2;
      'h16B, 'h01C: return 3;
      default:      return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ext  = 0;
    m_brk  = 0;
    m_idle = 0;
    m_held = -1;
    m_disp = 16'h0000;
    m_ovf  = 0;
    m_last = -1;
  endtask

  task automatic model_step(input bit v, input logic [7:0] c, input bit r);
    bit pop;
    int push_dir;
    int key;
    int d;
    bit blocked;
    pop      = (m_q.size() > 0) && r;
    push_dir = -1;
    m_ovf    = 0;
    if (v) begin
      m_idle = 0;
      key    = int'(m_ext) * 256 + int'(c);
      if (m_brk) begin
        if (key == m_held) m_held = -1;
        m_ext = 0;
        m_brk = 0;
      end else if (c == 8'hF0) begin
        m_brk = 1;
      end else if (c == 8'hE0) begin
        m_ext = 1;
      end else begin
        d = key_dir(key);
        if (d >= 0 && key != m_held) begin
          m_held  = key;
          m_disp  = {(m_ext ? 8'hE0 : 8'h00), c};
          blocked = 0;
`ifdef SNAKE_REVERSE_BLOCK_EN
          blocked = (m_last >= 0) && (d == (m_last ^ 2));
`endif
          if (!blocked) begin
            if (m_q.size() < DEPTH || pop) push_dir = d;
            else m_ovf = 1;
          end
        end
        m_ext = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_idle == TMO - 1) begin
        m_ext  = 0;
        m_brk  = 0;
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (push_dir >= 0) begin
      m_q.push_back(push_dir);
      m_last = push_dir;
    end
  endtask

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  task automatic check_model();
    check("model.dirValid",  32'(bus.dirValid),  32'(m_q.size() > 0));
    check("model.fifoCount", 32'(bus.fifoCount), 32'(m_q.size()));
    check("model.overflow",  32'(bus.overflow),  32'(m_ovf));
    check("model.dispCode",  32'(bus.dispCode),  32'(m_disp));
    if (m_q.size() > 0) check("model.dirOut", 32'(bus.dirOut), 32'(m_q[0]));
  endtask

  // Called at a negedge: drive one cycle, step model, sample at the next negedge.
  task automatic cycle(input bit v, input logic [7:0] c, input bit r);
    bus.codeValid = v;
    bus.codeIn    = c;
    bus.dirReady  = r;
    model_step(v, c, r);
    @(posedge clk);
    @(negedge clk);
    check_model();
    bus.codeValid = 1'b0;
    bus.dirReady  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset.fifoCount", 32'(bus.fifoCount), 32'd0);
    check("reset.dirValid",  32'(bus.dirValid),  32'd0);
    check("reset.dirOut",    32'(bus.dirOut),    32'd0);
    check("reset.overflow",  32'(bus.overflow),  32'd0);
    check("reset.dispCode",  32'(bus.dispCode),  32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          v;
    logic [7:0]  c;
    bit          r;
    int          cnt;
    int          dir;   // -1: do not check
    bit          ovf;
    logic [15:0] disp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit v, input logic [7:0] c, input bit r,
                              input int cnt, input int dir, input bit ovf, input logic [15:0] disp);
    vec_t e;
    e.v = v; e.c = c; e.r = r; e.cnt = cnt; e.dir = dir; e.ovf = ovf; e.disp = disp;
    tbl.push_back(e);
  endfunction

  logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
                            8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h12, 8'h5A};

  initial begin
    // single arrow key press and release
    add(1, 8'hE0, 0, 0, -1, 0, 16'h0000);
    add(1, 8'h75, 0, 1,  0, 0, 16'hE075);
    add(1, 8'hE0, 0, 1,  0, 0, 16'hE075);
    add(1, 8'hF0, 0, 1,  0, 0, 16'hE075);
    add(1, 8'h75, 0, 1,  0, 0, 16'hE075);
    add(0, 8'h00, 1, 0, -1, 0, 16'hE075);
    // typematic repeat
    add(1, 8'h1C, 0, 1,  3, 0, 16'h001C);
    add(1, 8'h1C, 0, 1,  3, 0, 16'h001C);
    add(1, 8'h1C, 0, 1,  3, 0, 16'h001C);
    add(1, 8'hF0, 0, 1,  3, 0, 16'h001C);
    add(1, 8'h1C, 0, 1,  3, 0, 16'h001C);
    add(1, 8'h1C, 0, 2,  3, 0, 16'h001C);
    add(0, 8'h00, 1, 1,  3, 0, 16'h001C);
    add(0, 8'h00, 1, 0, -1, 0, 16'h001C);
    add(1, 8'hF0, 0, 0, -1, 0, 16'h001C);
    add(1, 8'h1C, 0, 0, -1, 0, 16'h001C);
    // overflow: six keys, each released
    add(1, 8'h1D, 0, 1,  0, 0, 16'h001D);
    add(1, 8'hF0, 0, 1,  0, 0, 16'h001D);
    add(1, 8'h1D, 0, 1,  0, 0, 16'h001D);
    add(1, 8'h23, 0, 2,  0, 0, 16'h0023);
    add(1, 8'hF0, 0, 2,  0, 0, 16'h0023);
    add(1, 8'h23, 0, 2,  0, 0, 16'h0023);
    add(1, 8'h1B, 0, 3,  0, 0, 16'h001B);
    add(1, 8'hF0, 0, 3,  0, 0, 16'h001B);
    add(1, 8'h1B, 0, 3,  0, 0, 16'h001B);
    add(1, 8'h1C, 0, 4,  0, 0, 16'h001C);
    add(1, 8'hF0, 0, 4,  0, 0, 16'h001C);
    add(1, 8'h1C, 0, 4,  0, 0, 16'h001C);
    add(1, 8'h1D, 0, 4,  0, 1, 16'h001D);
    add(1, 8'hF0, 0, 4,  0, 0, 16'h001D);
    add(1, 8'h1D, 0, 4,  0, 0, 16'h001D);
    add(1, 8'h23, 0, 4,  0, 1, 16'h0023);
    add(1, 8'hF0, 0, 4,  0, 0, 16'h0023);
    add(1, 8'h23, 0, 4,  0, 0, 16'h0023);
    // full FIFO: push and pop together, then drain to see order
    add(1, 8'h1B, 1, 4,  1, 0, 16'h001B);
    add(0, 8'h00, 1, 3,  2, 0, 16'h001B);
    add(0, 8'h00, 1, 2,  3, 0, 16'h001B);
    add(0, 8'h00, 1, 1,  2, 0, 16'h001B);
    add(0, 8'h00, 1, 0, -1, 0, 16'h001B);
  end

  initial begin
    bus.codeIn    = 8'h00;
    bus.codeValid = 1'b0;
    bus.dirReady  = 1'b0;
    model_reset();
    do_reset();

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].r);
      check($sformatf("tbl[%0d].fifoCount", i), 32'(bus.fifoCount), 32'(tbl[i].cnt));
      check($sformatf("tbl[%0d].dirValid", i),  32'(bus.dirValid),  32'(tbl[i].cnt > 0));
      check($sformatf("tbl[%0d].overflow", i),  32'(bus.overflow),  32'(tbl[i].ovf));
      check($sformatf("tbl[%0d].dispCode", i),  32'(bus.dispCode),  32'(tbl[i].disp));
      if (tbl[i].dir >= 0)
        check($sformatf("tbl[%0d].dirOut", i), 32'(bus.dirOut), 32'(tbl[i].dir));
    end

    // E0 abandoned after a long idle gap: 74 decodes as plain (unmapped) 74
    cycle(1, 8'hE0, 0);
    repeat (TMO + 24) cycle(0, 8'h00, 0);
    cycle(1, 8'h74, 0);
    check("tmo.ext.count", 32'(bus.fifoCount), 32'd0);
    check("tmo.ext.disp",  32'(bus.dispCode),  32'h001B);
    cycle(1, 8'h1C, 0);
    check("tmo.idle.count", 32'(bus.fifoCount), 32'd1);
    check("tmo.idle.disp",  32'(bus.dispCode),  32'h001C);
    // short gap keeps the prefix
    cycle(1, 8'hE0, 0);
    repeat (5) cycle(0, 8'h00, 0);
    cycle(1, 8'h75, 0);
    check("tmo.short.count", 32'(bus.fifoCount), 32'd2);
    check("tmo.short.disp",  32'(bus.dispCode),  32'hE075);
    // F0 abandoned: 1C becomes a make
    cycle(1, 8'hF0, 0);
    repeat (TMO + 24) cycle(0, 8'h00, 0);
    cycle(1, 8'h1C, 0);
    check("tmo.brk.count", 32'(bus.fifoCount), 32'd3);
    check("tmo.brk.disp",  32'(bus.dispCode),  32'h001C);

    // reset with a non-empty FIFO, then reverse-direction sequence
    do_reset();
    cycle(1, 8'h1D, 0);
    cycle(1, 8'hF0, 0);
    cycle(1, 8'h1D, 0);
    cycle(1, 8'h1B, 0);
`ifdef SNAKE_REVERSE_BLOCK_EN
    rev_expect = 1;
`else
    rev_expect = 2;
`endif
    check("rev.count", 32'(bus.fifoCount), 32'(rev_expect));
    check("rev.head",  32'(bus.dirOut),    32'd0);
    check("rev.disp",  32'(bus.dispCode),  32'h001B);
    cycle(0, 8'h00, 1);
    if (rev_expect == 2) check("rev.second", 32'(bus.dirOut), 32'd2);
    cycle(0, 8'h00, 1);

    // random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      bit         v;
      logic [7:0] c;
      bit         r;
      v = ($urandom_range(0, (k < 2500) ? 1 : 24) == 0);
      c = pool[$urandom_range(0, 11)];
      r = ($urandom_range(0, 3) == 0);
      cycle(v, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
